// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The fetch FSM state encoding lives here so the top and any tooling agree on it.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    REQ_DROP,
    WAIT_DROP
  } fetch_state_t;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Small register-based FIFO holding {address, instruction} pairs for the decoder.
// Head is read straight from the slot registers; flush voids any same-cycle push/pop.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic [WIDTH-1:0] slot_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != FULL) || do_pop);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [WIDTH-1:0] slot_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        slot_reg <= '0;
      end else if (do_push && !flush && (wr_ptr_reg == AW'(gi))) begin
        slot_reg <= din;
      end
    end

    assign slot_q[gi] = slot_reg;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = slot_q[rd_ptr_reg];
  assign valid = (count_reg != '0);
  assign count = count_reg;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch stage: paces the PC, issues one memory read at a time and
// queues returned {address, instruction} pairs; redirects flush and drop stale data.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int NO_BITS    = 32,
  parameter int INSTR_BITS = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NO_BITS-1:0]      pc_addr,
  output logic                    pc_inc_en,
  output logic                    pc_sel,
  output logic [NO_BITS-1:0]      pc_init,
  input  logic                    redirect,
  input  logic [NO_BITS-1:0]      redirect_addr,
  output logic                    mem_req,
  output logic [NO_BITS-1:0]      mem_addr,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [INSTR_BITS-1:0]   mem_rdata,
  output logic                    instr_valid,
  output logic [INSTR_BITS-1:0]   instr_data,
  output logic [NO_BITS-1:0]      instr_addr,
  input  logic                    instr_ready,
  output logic [$clog2(DEPTH):0]  buf_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_t              state_reg, state_next;
  logic [NO_BITS-1:0]        mem_addr_reg, mem_addr_next;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic                      grant_adv;
  logic [CW-1:0]             count_after;
  logic [NO_BITS+INSTR_BITS-1:0] fifo_head;

  assign fifo_pop = instr_valid && instr_ready;

  fetch_fifo #(
    .WIDTH(NO_BITS + INSTR_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .din   ({mem_addr_reg, mem_rdata}),
    .head  (fifo_head),
    .valid (instr_valid),
    .count (buf_count)
  );

  assign instr_addr = fifo_head[NO_BITS+INSTR_BITS-1:INSTR_BITS];
  assign instr_data = fifo_head[INSTR_BITS-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      mem_addr_reg <= '0;
    end else begin
      state_reg    <= state_next;
      mem_addr_reg <= mem_addr_next;
    end
  end

  // A request is only launched with a free slot, so the response can always be pushed.
  always_comb begin
    state_next    = state_reg;
    mem_addr_next = mem_addr_reg;
    fifo_push     = 1'b0;
    grant_adv     = 1'b0;
    count_after   = buf_count + CW'(mem_rvalid) - CW'(fifo_pop);
    case (state_reg)
      IDLE: begin
        if (!redirect && (buf_count < FULL)) begin
          state_next    = REQ;
          mem_addr_next = pc_addr;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          grant_adv  = 1'b1;
          state_next = redirect ? WAIT_DROP : WAIT;
        end else if (redirect) begin
          state_next = REQ_DROP;
        end
      end
      WAIT: begin
        if (redirect) begin
          state_next = mem_rvalid ? IDLE : WAIT_DROP;
        end else if (mem_rvalid) begin
          fifo_push = 1'b1;
          if (count_after < FULL) begin
            state_next    = REQ;
            mem_addr_next = pc_addr;
          end else begin
            state_next = IDLE;
          end
        end
      end
      REQ_DROP: begin
        if (mem_gnt) state_next = WAIT_DROP;
      end
      WAIT_DROP: begin
        if (mem_rvalid) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_req   = (state_reg == REQ) || (state_reg == REQ_DROP);
  assign mem_addr  = mem_addr_reg;
  assign pc_sel    = redirect;
  assign pc_init   = redirect_addr;
  assign pc_inc_en = redirect || grant_adv;

endmodule

// File: tb/tb_fetch_buffer.sv
// Randomized bench for fetch_buffer: a PC register and memory responder drive the DUT,
// an expected address stream is queued on reset/redirect and a monitor pops and compares.
module tb_fetch_buffer;

  localparam int NB    = 32;
  localparam int IB    = 32;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] pc_addr = '0;
  logic          pc_inc_en, pc_sel;
  logic [NB-1:0] pc_init;
  logic          redirect = 1'b0;
  logic [NB-1:0] redirect_addr = '0;
  logic          mem_req;
  logic [NB-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [IB-1:0] mem_rdata = '0;
  logic          instr_valid;
  logic [IB-1:0] instr_data;
  logic [NB-1:0] instr_addr;
  logic          instr_ready = 1'b1;
  logic [$clog2(DEPTH):0] buf_count;

  always #5 clk = ~clk;

  fetch_buffer #(.NO_BITS(NB), .INSTR_BITS(IB), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_inc_en(pc_inc_en), .pc_sel(pc_sel),
    .pc_init(pc_init), .redirect(redirect), .redirect_addr(redirect_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr_data(instr_data),
    .instr_addr(instr_addr), .instr_ready(instr_ready), .buf_count(buf_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_pops = 0;
  logic [NB-1:0] exp_q[$];
  int gnt_delay = 0;
  int rv_lat = 1;
  bit rand_lat = 1'b0;

  function automatic logic [IB-1:0] mem_word(input logic [NB-1:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // The fetched stream after a reset or redirect is simply target, target+4, ...
  task automatic expect_stream(input logic [NB-1:0] base);
    exp_q.delete();
    for (int i = 0; i < 600; i++) exp_q.push_back(base + NB'(4 * i));
  endtask

  task automatic wait_pops(input int k, input int budget, input string name);
    int target;
    bit done;
    target = n_pops + k;
    done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (n_pops >= target) done = 1'b1;
    end
    if (!done) timeout(name);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_buf_count", buf_count, 0);
    check("rst_pc_inc_en", pc_inc_en, 0);
    check("rst_pc_sel", pc_sel, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    expect_stream('0);
  endtask

  // PC register and instruction memory: update after each rising edge from values sampled before it.
  initial begin
    bit busy = 1'b0;
    int left = 0;
    int waited = 0;
    int cur_delay = 0;
    logic [NB-1:0] paddr = '0;
    bit s_grant, s_rv, s_inc, s_sel;
    logic [NB-1:0] s_addr, s_init;
    forever begin
      @(negedge clk);
      s_grant = mem_req && mem_gnt;
      s_addr  = mem_addr;
      s_rv    = mem_rvalid;
      s_inc   = pc_inc_en;
      s_sel   = pc_sel;
      s_init  = pc_init;
      @(posedge clk); #1;
      if (!rst) pc_addr = '0;
      else if (s_inc) pc_addr = s_sel ? s_init : pc_addr + 32'd4;
      if (s_rv) begin
        mem_rvalid = 1'b0;
        mem_rdata  = $urandom;
        busy       = 1'b0;
      end
      if (s_grant) begin
        busy   = 1'b1;
        paddr  = s_addr;
        left   = (rand_lat ? int'($urandom_range(1, 5)) : rv_lat) - 1;
        waited = 0;
      end
      if (busy && !mem_rvalid) begin
        if (left <= 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_word(paddr);
        end else begin
          left--;
        end
      end
      if (mem_req && !busy) begin
        if (waited == 0) cur_delay = rand_lat ? int'($urandom_range(0, 3)) : gnt_delay;
        if (waited >= cur_delay) mem_gnt = 1'b1;
        else begin
          mem_gnt = 1'b0;
          waited++;
        end
      end else begin
        mem_gnt = 1'b0;
        waited  = 0;
      end
    end
  end

  // Monitor: protocol checks every cycle and scoreboard pop on each accepted head.
  initial begin
    bit stale = 1'b0;
    bit prev_pend = 1'b0;
    logic [NB-1:0] prev_addr = '0;
    logic [NB-1:0] a;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stale = 1'b0;
        prev_pend = 1'b0;
        continue;
      end
      check("pc_sel", pc_sel, redirect);
      check("pc_init", pc_init, redirect_addr);
      check("pc_inc_en", pc_inc_en, redirect || (mem_req && mem_gnt && !stale));
      check("count_bound", buf_count <= DEPTH, 1);
      check("valid_vs_count", instr_valid, buf_count != 0);
      if (mem_req) check("reserve_slot", buf_count < DEPTH, 1);
      if (prev_pend) begin
        check("req_held", mem_req, 1);
        check("addr_held", mem_addr, prev_addr);
      end
      if (instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          timeout("unexpected_instr");
        end else begin
          a = exp_q.pop_front();
          check("instr_addr", instr_addr, a);
          check("instr_data", instr_data, mem_word(a));
        end
        n_pops++;
      end
      if (mem_req && mem_gnt) stale = 1'b0;
      else if (mem_req && redirect) stale = 1'b1;
      prev_pend = mem_req && !mem_gnt;
      prev_addr = mem_addr;
    end
  end

  initial begin
    int rises;
    bit found;
    bit prev_req;
    logic [NB-1:0] first_addr;
    logic [NB-1:0] tgt;

    // 1: streaming from reset
    instr_ready = 1'b1;
    gnt_delay = 0;
    rv_lat = 1;
    do_reset();
    wait_pops(4, 40, "t1_stream");

    // 2: backpressure fills the buffer, one pop frees exactly one request
    instr_ready = 1'b0;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (buf_count == DEPTH) found = 1'b1;
    end
    if (!found) timeout("t2_fill");
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("t2_full_no_req", mem_req, 0);
      check("t2_full_count", buf_count, DEPTH);
    end
    @(posedge clk); #1 instr_ready = 1'b1;
    @(posedge clk); #1 instr_ready = 1'b0;
    @(negedge clk);
    check("t2_count_after_pop", buf_count, DEPTH - 1);
    rises = 0;
    prev_req = mem_req;
    first_addr = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (rises == 0) first_addr = mem_addr;
        rises++;
      end
      prev_req = mem_req;
    end
    check("t2_one_request", rises, 1);
    check("t2_request_addr", first_addr, 32'h10);
    check("t2_refilled", buf_count, DEPTH);

    // 3: redirect while waiting for the 0x8 response
    instr_ready = 1'b1;
    rv_lat = 3;
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (mem_req && mem_gnt && mem_addr == 32'h8) found = 1'b1;
    end
    if (!found) timeout("t3_wait_0x8");
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_addr = 32'h100;
    expect_stream(32'h100);
    @(negedge clk);
    check("t3_pc_sel", pc_sel, 1);
    check("t3_pc_inc_en", pc_inc_en, 1);
    @(posedge clk); #1 redirect = 1'b0;
    @(negedge clk);
    check("t3_flushed", buf_count, 0);
    wait_pops(2, 60, "t3_after_redirect");

    // 4: redirect while a request waits three cycles for grant
    gnt_delay = 3;
    rv_lat = 2;
    found = 1'b0;
    prev_req = 1'b1;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      if (mem_req && !mem_gnt && !prev_req) found = 1'b1;
      prev_req = mem_req;
    end
    if (!found) timeout("t4_req_start");
    first_addr = mem_addr;
    @(posedge clk); #1;
    redirect = 1'b1;
    redirect_addr = 32'h200;
    expect_stream(32'h200);
    @(posedge clk); #1 redirect = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      check("t4_addr_stable", mem_addr, first_addr);
      if (mem_gnt) found = 1'b1;
    end
    if (!found) timeout("t4_grant");
    wait_pops(3, 80, "t4_after_redirect");

    // 5: reset in the middle of a wait, late response must be ignored
    gnt_delay = 0;
    rv_lat = 6;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (mem_req && mem_gnt) found = 1'b1;
    end
    if (!found) timeout("t5_grant");
    @(posedge clk); #1;
    do_reset();
    wait_pops(3, 80, "t5_restart");

    // 6: slow memory with random backpressure, then random latencies and redirects
    gnt_delay = 3;
    rv_lat = 5;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      instr_ready = $urandom_range(0, 1) == 1;
    end
    rand_lat = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      instr_ready = $urandom_range(0, 2) != 0;
      if (redirect) redirect = 1'b0;
      else if ($urandom_range(0, 39) == 0) begin
        tgt = NB'($urandom_range(0, 65535)) << 2;
        redirect = 1'b1;
        redirect_addr = tgt;
        expect_stream(tgt);
      end
    end
    @(posedge clk); #1;
    redirect = 1'b0;
    instr_ready = 1'b1;
    wait_pops(3, 100, "t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
